// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: pending-write bitmap, RAW/WAW/structural/capacity stalls,
// and the iterative divider sequencer. Optional macro SCOREBOARD_WB_BYPASS_EN masks RAW on same-cycle writeback.
module issue_scoreboard #(
  parameter int DIV_LAT      = 34,
  parameter int MAX_INFLIGHT = 4,
  parameter int FU_W         = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic [4:0]                        rs1_i,
  input  logic [4:0]                        rs2_i,
  input  logic                              rs1_used_i,
  input  logic                              rs2_used_i,
  input  logic [4:0]                        rd_i,
  input  logic                              reg_wb_i,
  input  logic [FU_W-1:0]                   fu_sel_i,
  input  logic                              flush_i,
  input  logic                              wb_valid_i,
  input  logic [4:0]                        wb_rd_i,
  output logic                              div_start_o,
  output logic                              div_done_o,
  output logic                              div_busy_o,
  output logic [31:0]                       pending_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic [1:0]                        hazard_o
);

  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [FU_W-1:0]  FU_DIV     = FU_W'(5);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV_LAT - 2);
  localparam logic [IF_W-1:0]  IF_MAX     = IF_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      pending_r, pending_s;
  logic [IF_W-1:0]  inflight_r, inflight_s;

  logic        tracked_s, byp1_s, byp2_s, raw_s, waw_s, struct_s, full_s;
  logic        stall_s, fire_s, div_fire_s, inc_s, dec_s;
  logic [31:0] set_mask_s, clr_mask_s;

  // Same-cycle writeback forwarding hides a RAW dependency on the register being written back.
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign byp1_s = wb_valid_i && (wb_rd_i == rs1_i);
  assign byp2_s = wb_valid_i && (wb_rd_i == rs2_i);
`else
  assign byp1_s = 1'b0;
  assign byp2_s = 1'b0;
`endif

  assign tracked_s  = reg_wb_i && (rd_i != 5'd0);
  assign raw_s      = (rs1_used_i && pending_r[rs1_i] && !byp1_s) ||
                      (rs2_used_i && pending_r[rs2_i] && !byp2_s);
  assign waw_s      = tracked_s && pending_r[rd_i];
  assign struct_s   = (fu_sel_i == FU_DIV) && (state_r == DIV_BUSY);
  assign full_s     = tracked_s && (inflight_r == IF_MAX);
  assign stall_s    = issue_valid_i && (raw_s || waw_s || struct_s || full_s);
  assign fire_s     = issue_valid_i && !stall_s && !flush_i;
  assign div_fire_s = fire_s && (fu_sel_i == FU_DIV);
  assign inc_s      = fire_s && tracked_s;
  assign dec_s      = wb_valid_i && pending_r[wb_rd_i];
  assign set_mask_s = inc_s ? (32'd1 << rd_i) : 32'd0;
  assign clr_mask_s = dec_s ? (32'd1 << wb_rd_i) : 32'd0;

  // Handshake, hazard code and divider status decode.
  always_comb begin
    issue_ready_o = !stall_s;
    div_start_o   = div_fire_s;
    div_busy_o    = (state_r == DIV_BUSY);
    div_done_o    = (state_r == DIV_DONE);
    pending_o     = pending_r;
    inflight_o    = inflight_r;
    if (flush_i) begin
      hazard_o = 2'b11;
    end else if (stall_s) begin
      hazard_o = 2'b01;
    end else begin
      hazard_o = 2'b00;
    end
  end

  // Next pending bitmap (set beats clear, x0 forced clean) and saturating in-flight count.
  always_comb begin
    pending_s  = ((pending_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    inflight_s = inflight_r;
    if (inc_s && !dec_s && (inflight_r != IF_MAX)) begin
      inflight_s = inflight_r + IF_W'(1);
    end else if (dec_s && !inc_s && (inflight_r != IF_W'(0))) begin
      inflight_s = inflight_r - IF_W'(1);
    end else begin
      inflight_s = inflight_r;
    end
  end

  // Divider sequencer next state; a DIV accepted in DONE restarts without passing through IDLE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      DIV_IDLE: begin
        if (div_fire_s) begin
          state_s = DIV_BUSY;
          cnt_s   = CNT_RELOAD;
        end else begin
          state_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (cnt_r == CNT_W'(0)) begin
          state_s = DIV_DONE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      DIV_DONE: begin
        if (div_fire_s) begin
          state_s = DIV_BUSY;
          cnt_s   = CNT_RELOAD;
        end else begin
          state_s = DIV_IDLE;
        end
      end
      default: begin
        state_s = DIV_IDLE;
        cnt_s   = CNT_W'(0);
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= DIV_IDLE;
      cnt_r      <= CNT_W'(0);
      pending_r  <= 32'd0;
      inflight_r <= IF_W'(0);
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pending_r  <= pending_s;
      inflight_r <= inflight_s;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: vector table with a pending/inflight
// scoreboard queue, plus hand-written divider, flush and async-reset sequences.
module tb_issue_scoreboard;

  localparam int DIV_LAT = 34;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i, rst_ni;
  logic        issue_valid_i, issue_ready_o;
  logic [4:0]  rs1_i, rs2_i, rd_i, wb_rd_i;
  logic        rs1_used_i, rs2_used_i, reg_wb_i, flush_i, wb_valid_i;
  logic [2:0]  fu_sel_i;
  logic        div_start_o, div_done_o, div_busy_o;
  logic [31:0] pending_o;
  logic [2:0]  inflight_o;
  logic [1:0]  hazard_o;

  int errors = 0;
  int checks = 0;

  issue_scoreboard #(.DIV_LAT(DIV_LAT), .MAX_INFLIGHT(4), .FU_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_i(rd_i), .reg_wb_i(reg_wb_i), .fu_sel_i(fu_sel_i), .flush_i(flush_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .div_start_o(div_start_o), .div_done_o(div_done_o), .div_busy_o(div_busy_o),
    .pending_o(pending_o), .inflight_o(inflight_o), .hazard_o(hazard_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic        rs1u;
    logic [4:0]  rs2;
    logic        rs2u;
    logic [4:0]  rd;
    logic        wb;
    logic [2:0]  fu;
    logic        flush;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        exp_ready;
    logic [1:0]  exp_haz;
    logic [31:0] exp_pend;
    logic [2:0]  exp_infl;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] pend;
    logic [2:0]  infl;
    string       name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  function automatic vec_t mk(input logic v, input logic [4:0] r1, input logic u1,
                              input logic [4:0] r2, input logic u2, input logic [4:0] d,
                              input logic w, input logic [2:0] f, input logic fl,
                              input logic wv, input logic [4:0] wr, input logic er,
                              input logic [1:0] eh, input logic [31:0] ep,
                              input logic [2:0] ei, input string nm);
    vec_t t;
    t.valid = v; t.rs1 = r1; t.rs1u = u1; t.rs2 = r2; t.rs2u = u2; t.rd = d;
    t.wb = w; t.fu = f; t.flush = fl; t.wbv = wv; t.wbrd = wr;
    t.exp_ready = er; t.exp_haz = eh; t.exp_pend = ep; t.exp_infl = ei; t.name = nm;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    issue_valid_i = t.valid; rs1_i = t.rs1; rs1_used_i = t.rs1u;
    rs2_i = t.rs2; rs2_used_i = t.rs2u; rd_i = t.rd; reg_wb_i = t.wb;
    fu_sel_i = t.fu; flush_i = t.flush; wb_valid_i = t.wbv; wb_rd_i = t.wbrd;
  endtask

  task automatic idle();
    drive(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0,
             1'b1, 2'b00, 32'd0, 3'd0, "idle"));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    bit   fired;
    rst_ni = 1'b0;
    idle();

    //      v   rs1   u   rs2   u   rd   wb  fu  fl  wbv wbrd  ready  haz  pending  infl
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 3'd0, 0, 0, 5'd0, 1, 2'b00, 32'h20, 3'd1, "add_rd5"));
    tbl.push_back(mk(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 3'd0, 0, 0, 5'd0, 0, 2'b01, 32'h20, 3'd1, "raw_rs1_a"));
    tbl.push_back(mk(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 3'd0, 0, 0, 5'd0, 0, 2'b01, 32'h20, 3'd1, "raw_rs1_b"));
    tbl.push_back(mk(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 3'd0, 0, 1, 5'd5, BYP, BYP ? 2'b00 : 2'b01,
                     BYP ? 32'h40 : 32'h0, BYP ? 3'd1 : 3'd0, "raw_wb_cycle"));
    tbl.push_back(mk(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 3'd0, 0, 0, 5'd0, !BYP, BYP ? 2'b01 : 2'b00,
                     32'h40, 3'd1, "raw_after_wb"));
    tbl.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0, 1, 5'd6, 1, 2'b00, 32'h0, 3'd0, "wb_rd6"));
    tbl.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0, 1, 5'd3, 1, 2'b00, 32'h0, 3'd0, "wb_not_pending"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 3'd0, 0, 0, 5'd0, 1, 2'b00, 32'h0, 3'd0, "x0_dest"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 3'd0, 0, 0, 5'd0, 1, 2'b00, 32'h02, 3'd1, "fill_rd1"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 3'd2, 0, 0, 5'd0, 1, 2'b00, 32'h06, 3'd2, "fill_rd2"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 3'd4, 0, 0, 5'd0, 1, 2'b00, 32'h0E, 3'd3, "fill_rd3_mul"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 3'd6, 0, 0, 5'd0, 1, 2'b00, 32'h1E, 3'd4, "fill_rd4"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 3'd0, 0, 0, 5'd0, 0, 2'b01, 32'h1E, 3'd4, "full_stall"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 3'd0, 0, 1, 5'd2, 0, 2'b01, 32'h1A, 3'd3, "full_wb_rd2"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 3'd0, 0, 0, 5'd0, 1, 2'b00, 32'h5A, 3'd4, "full_release"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd8, 0, 3'd3, 0, 0, 5'd0, 1, 2'b00, 32'h5A, 3'd4, "untracked_full"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 3'd0, 1, 0, 5'd0, 0, 2'b11, 32'h5A, 3'd4, "flush_over_stall"));
    tbl.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0, 1, 5'd1, 1, 2'b00, 32'h58, 3'd3, "wb_rd1"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 3'd0, 0, 1, 5'd3, 1, 2'b00, 32'h250, 3'd3, "inc_dec_same"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 3'd0, 0, 1, 5'd9, 0, 2'b01, 32'h50, 3'd2, "waw_wb_rd9"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 3'd0, 0, 0, 5'd0, 1, 2'b00, 32'h250, 3'd3, "reissue_rd9"));
    tbl.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0, 1, 5'd4, 1, 2'b00, 32'h240, 3'd2, "drain_rd4"));
    tbl.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0, 1, 5'd6, 1, 2'b00, 32'h200, 3'd1, "drain_rd6"));
    tbl.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0, 1, 5'd9, 1, 2'b00, 32'h0, 3'd0, "drain_rd9"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 3'd0, 0, 0, 5'd0, 1, 2'b00, 32'h400, 3'd1, "add_rd10"));
    tbl.push_back(mk(1, 5'd10, 0, 5'd0, 0, 5'd0, 0, 3'd3, 0, 0, 5'd0, 1, 2'b00, 32'h400, 3'd1, "rs1_unused"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd10, 1, 5'd0, 0, 3'd3, 0, 0, 5'd0, 0, 2'b01, 32'h400, 3'd1, "raw_rs2"));
    tbl.push_back(mk(1, 5'd0, 0, 5'd10, 1, 5'd0, 0, 3'd3, 0, 1, 5'd10, BYP, BYP ? 2'b00 : 2'b01,
                     32'h0, 3'd0, "raw_rs2_wb"));
    tbl.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 3'd0, 0, 0, 5'd0, 1, 2'b00, 32'h0, 3'd0, "quiet"));

    #12;
    chk("reset_pending", pending_o, 32'h0);
    chk("reset_inflight", inflight_o, 3'd0);
    chk("reset_busy", div_busy_o, 1'b0);
    chk("reset_done", div_done_o, 1'b0);
    chk("reset_start", div_start_o, 1'b0);
    chk("reset_ready", issue_ready_o, 1'b1);
    chk("reset_hazard", hazard_o, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      drive(tbl[i]);
      sb_q.push_back('{tbl[i].exp_pend, tbl[i].exp_infl, tbl[i].name});
      #1;
      chk({tbl[i].name, "_ready"}, issue_ready_o, tbl[i].exp_ready);
      chk({tbl[i].name, "_hazard"}, hazard_o, tbl[i].exp_haz);
      chk({tbl[i].name, "_start"}, div_start_o, 1'b0);
      @(posedge clk_i);
      #1;
      e = sb_q.pop_front();
      chk({e.name, "_pending"}, pending_o, e.pend);
      chk({e.name, "_inflight"}, inflight_o, e.infl);
    end

    // DIV rd=7 fires; a second DIV rd=8 waits out the structural stall.
    @(negedge clk_i);
    drive(mk(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 3'd5, 0, 0, 5'd0, 1, 2'b00, 32'h0, 3'd0, "div1"));
    #1;
    chk("div1_start", div_start_o, 1'b1);
    chk("div1_ready", issue_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    chk("div1_busy", div_busy_o, 1'b1);
    chk("div1_pending", pending_o, 32'h80);
    fired = 1'b0;
    for (int k = 1; k <= DIV_LAT + 4; k++) begin
      @(negedge clk_i);
      drive(mk(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 3'd5, 0, 0, 5'd0, 1, 2'b00, 32'h0, 3'd0, "div2"));
      #1;
      chk("div2_ready", issue_ready_o, (k == DIV_LAT));
      chk("div2_hazard", hazard_o, (k == DIV_LAT) ? 2'b00 : 2'b01);
      chk("div1_busy_window", div_busy_o, (k < DIV_LAT));
      chk("div1_done_pulse", div_done_o, (k == DIV_LAT));
      chk("div2_start", div_start_o, (k == DIV_LAT));
      if (issue_ready_o) begin
        fired = 1'b1;
        break;
      end
    end
    chk("div2_fired", fired, 1'b1);
    @(posedge clk_i);
    #1;
    chk("div2_busy", div_busy_o, 1'b1);
    chk("div2_done_low", div_done_o, 1'b0);
    chk("div2_pending", pending_o, 32'h180);
    chk("div2_inflight", inflight_o, 3'd2);
    n = 0;
    for (int k = 1; k <= DIV_LAT + 5; k++) begin
      @(negedge clk_i);
      idle();
      #1;
      if (div_done_o) begin
        n = k;
        break;
      end
    end
    chk("div2_latency", n, DIV_LAT);

    // Flush of a DIV with the divider idle: no start, bitmap untouched.
    @(negedge clk_i);
    drive(mk(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 3'd5, 1, 0, 5'd0, 1, 2'b00, 32'h0, 3'd0, "flush_div"));
    #1;
    chk("flush_hazard", hazard_o, 2'b11);
    chk("flush_start", div_start_o, 1'b0);
    chk("flush_ready", issue_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    chk("flush_pending", pending_o, 32'h180);
    chk("flush_busy", div_busy_o, 1'b0);
    chk("flush_inflight", inflight_o, 3'd2);

    // Async reset while a divide is in progress.
    @(negedge clk_i);
    drive(mk(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 3'd5, 0, 0, 5'd0, 1, 2'b00, 32'h0, 3'd0, "div3"));
    #1;
    chk("div3_start", div_start_o, 1'b1);
    @(negedge clk_i);
    idle();
    repeat (3) @(posedge clk_i);
    #2;
    chk("div3_busy_pre", div_busy_o, 1'b1);
    chk("div3_pending_pre", pending_o, 32'h2180);
    rst_ni = 1'b0;
    #1;
    chk("rst_busy", div_busy_o, 1'b0);
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_inflight", inflight_o, 3'd0);
    chk("rst_done", div_done_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_busy", div_busy_o, 1'b0);
    chk("post_rst_done", div_done_o, 1'b0);
    chk("post_rst_pending", pending_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
